// File: rtl/renode_input_monitor_if.sv
// Message channel from the input monitor toward the Renode connection sender.
// Latency: none, wires only.
// Backpressure: valid/ready; master holds address/data stable while valid && !ready.
interface renode_input_monitor_if #(
  parameter int AddressWidth = 64,
  parameter int DataWidth    = 64
);
  logic                    msg_valid;
  logic                    msg_ready;
  logic [AddressWidth-1:0] msg_address;
  logic [DataWidth-1:0]    msg_data;

  modport master (
    output msg_valid,
    output msg_address,
    output msg_data,
    input  msg_ready
  );

  modport slave (
    input  msg_valid,
    input  msg_address,
    input  msg_data,
    output msg_ready
  );
endinterface

// File: rtl/renode_input_monitor.sv
// Reports every GPIO level change as a (line index, new level) message, lowest index first.
// Latency: a change registered at edge E0 appears on msg_valid after E1 when the slot is free.
// Backpressure: the message register holds while stalled; later changes wait in the sample/reported mismatch.
module renode_input_monitor #(
  parameter int InputsCount  = 1,
  parameter int AddressWidth = 64,
  parameter int DataWidth    = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [InputsCount-1:0] inputs,
  renode_input_monitor_if.master msg
);

  localparam int IdxW = (InputsCount > 1) ? $clog2(InputsCount) : 1;

  logic [InputsCount-1:0]  sample_q;
  logic [InputsCount-1:0]  reported_q;
  logic [InputsCount-1:0]  pending;
  logic [InputsCount-1:0]  candidates;
  logic                    valid_q;
  logic [AddressWidth-1:0] address_q;
  logic [DataWidth-1:0]    data_q;
  logic                    transfer;
  logic                    slot_free;
  logic                    sel_found;
  logic [IdxW-1:0]         sel_idx;
  logic [IdxW-1:0]         xfer_idx;

  assign transfer  = valid_q && msg.msg_ready;
  assign slot_free = !valid_q || transfer;
  // The address register only ever holds values below InputsCount.
  assign xfer_idx  = address_q[IdxW-1:0];
  assign pending   = sample_q ^ reported_q;

  // Pick the lowest pending line; the line transferring now is not re-picked
  // because its reported level only updates at this same edge.
  always_comb begin
    candidates = pending;
    sel_found  = 1'b0;
    sel_idx    = '0;
    if (transfer) begin
      candidates[xfer_idx] = 1'b0;
    end
    for (int i = 0; i < InputsCount; i++) begin
      if (candidates[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
  end

  // Sample the lines and record the level Renode has accepted for each line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_q   <= '0;
      reported_q <= '0;
    end else begin
      sample_q <= inputs;
      if (transfer) begin
        reported_q[xfer_idx] <= data_q[0];
      end
    end
  end

  // Load the next message whenever the slot frees; otherwise hold it stable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
    end else if (slot_free) begin
      if (sel_found) begin
        valid_q   <= 1'b1;
        address_q <= AddressWidth'(sel_idx);
        data_q    <= DataWidth'(sample_q[sel_idx]);
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign msg.msg_valid   = valid_q;
  assign msg.msg_address = address_q;
  assign msg.msg_data    = data_q;

endmodule

// File: tb/tb_renode_input_monitor.sv
// Bench for renode_input_monitor with four lines: directed scenarios then random traffic.
// Latency: outputs compared every cycle against a behavioural message model.
// Backpressure: msg_ready is stalled in directed cases and randomly toggled afterwards.
module tb_renode_input_monitor;

  localparam int N = 4;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] inputs;

  int checks   = 0;
  int failures = 0;
  int l0_msgs  = 0;

  // Behavioural model: what has been sampled, what Renode has been told,
  // and the message currently offered.
  bit model_smp [N];
  bit model_rep [N];
  bit model_mv;
  int model_ma;
  bit model_md;

  renode_input_monitor_if #(.AddressWidth(64), .DataWidth(64)) ifc ();

  renode_input_monitor #(
    .InputsCount (N),
    .AddressWidth(64),
    .DataWidth   (64)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .inputs (inputs),
    .msg    (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the stimulus presented to the DUT.
  task automatic model_step(input logic [N-1:0] in_v, input logic rdy, input logic rst_n);
    bit want [N];
    bit accepted;
    int pick;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        model_smp[i] = 0;
        model_rep[i] = 0;
      end
      model_mv = 0;
      model_ma = 0;
      model_md = 0;
      return;
    end
    accepted = model_mv && rdy;
    for (int i = 0; i < N; i++) want[i] = (model_smp[i] != model_rep[i]);
    if (accepted) begin
      want[model_ma]      = 0;
      model_rep[model_ma] = model_md;
    end
    if (!model_mv || accepted) begin
      pick = -1;
      for (int i = N - 1; i >= 0; i--) if (want[i]) pick = i;
      if (pick >= 0) begin
        model_mv = 1;
        model_ma = pick;
        model_md = model_smp[pick];
      end else begin
        model_mv = 0;
      end
    end
    for (int i = 0; i < N; i++) model_smp[i] = in_v[i];
  endtask

  // One clock: drive, compare at the falling edge, step the model, cross the rising edge.
  task automatic cycle(input logic [N-1:0] in_v, input logic rdy, input logic rst_n);
    inputs        = in_v;
    ifc.msg_ready = rdy;
    reset_n       = rst_n;
    @(negedge clk);
    chk("model_valid", {63'd0, ifc.msg_valid}, {63'd0, model_mv});
    if (model_mv) begin
      chk("model_address", ifc.msg_address, 64'(model_ma));
      chk("model_data", ifc.msg_data, {63'd0, model_md});
    end
    if (ifc.msg_valid === 1'b1 && rdy && rst_n && ifc.msg_address == 64'd0) l0_msgs++;
    model_step(in_v, rdy, rst_n);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_msg(input string tag, input logic v, input logic [63:0] a, input logic [63:0] d);
    chk({tag, "_valid"}, {63'd0, ifc.msg_valid}, {63'd0, v});
    if (v) begin
      chk({tag, "_addr"}, ifc.msg_address, a);
      chk({tag, "_data"}, ifc.msg_data, d);
    end
  endtask

  initial begin
    logic [N-1:0] cur;
    model_mv = 0;
    model_ma = 0;
    model_md = 0;
    for (int i = 0; i < N; i++) begin
      model_smp[i] = 0;
      model_rep[i] = 0;
    end

    // Reset, then idle with ready held high: nothing is reported.
    repeat (3) cycle(4'b0000, 1'b1, 1'b0);
    expect_msg("reset", 1'b0, 64'd0, 64'd0);
    chk("reset_addr", ifc.msg_address, 64'd0);
    chk("reset_data", ifc.msg_data, 64'd0);
    repeat (10) cycle(4'b0000, 1'b1, 1'b1);
    expect_msg("idle", 1'b0, 64'd0, 64'd0);

    // Single line rises then falls; valid two cycles after each change.
    cycle(4'b0100, 1'b1, 1'b1);
    expect_msg("rise_early", 1'b0, 64'd0, 64'd0);
    cycle(4'b0100, 1'b1, 1'b1);
    expect_msg("rise", 1'b1, 64'd2, 64'd1);
    cycle(4'b0100, 1'b1, 1'b1);
    expect_msg("rise_done", 1'b0, 64'd0, 64'd0);
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1);
    expect_msg("fall", 1'b1, 64'd2, 64'd0);
    cycle(4'b0000, 1'b1, 1'b1);
    expect_msg("fall_done", 1'b0, 64'd0, 64'd0);

    // Three simultaneous changes drain back-to-back in index order.
    cycle(4'b1011, 1'b1, 1'b1);
    cycle(4'b1011, 1'b1, 1'b1);
    expect_msg("multi0", 1'b1, 64'd0, 64'd1);
    cycle(4'b1011, 1'b1, 1'b1);
    expect_msg("multi1", 1'b1, 64'd1, 64'd1);
    cycle(4'b1011, 1'b1, 1'b1);
    expect_msg("multi3", 1'b1, 64'd3, 64'd1);
    cycle(4'b1011, 1'b1, 1'b1);
    expect_msg("multi_done", 1'b0, 64'd0, 64'd0);
    repeat (6) cycle(4'b0000, 1'b1, 1'b1);

    // Backpressure: message stays put while the line toggles underneath it.
    cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0010, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      expect_msg("stall_hi", 1'b1, 64'd1, 64'd1);
      cycle(4'b0010, 1'b0, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, 1'b0, 1'b1);
      expect_msg("stall_lo", 1'b1, 64'd1, 64'd1);
    end
    cycle(4'b0000, 1'b1, 1'b1);
    expect_msg("stall_gap", 1'b0, 64'd0, 64'd0);
    cycle(4'b0000, 1'b1, 1'b1);
    expect_msg("stall_fall", 1'b1, 64'd1, 64'd0);
    cycle(4'b0000, 1'b1, 1'b1);
    expect_msg("stall_done", 1'b0, 64'd0, 64'd0);

    // Reset drops a stalled message; held lines are reported again afterwards.
    cycle(4'b1001, 1'b0, 1'b1);
    cycle(4'b1001, 1'b0, 1'b1);
    expect_msg("pre_rst", 1'b1, 64'd0, 64'd1);
    cycle(4'b1001, 1'b0, 1'b0);
    expect_msg("in_rst", 1'b0, 64'd0, 64'd0);
    cycle(4'b1001, 1'b1, 1'b1);
    cycle(4'b1001, 1'b1, 1'b1);
    expect_msg("rerep0", 1'b1, 64'd0, 64'd1);
    cycle(4'b1001, 1'b1, 1'b1);
    expect_msg("rerep3", 1'b1, 64'd3, 64'd1);
    repeat (6) cycle(4'b0000, 1'b1, 1'b1);

    // Short pulse on line 0 while line 3 is stalled: no line 0 message.
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b1);
    expect_msg("glitch_hold", 1'b1, 64'd3, 64'd1);
    l0_msgs = 0;
    cycle(4'b1001, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b1);
    repeat (2) cycle(4'b1000, 1'b0, 1'b1);
    repeat (6) cycle(4'b1000, 1'b1, 1'b1);
    chk("glitch_l0_msgs", 64'(l0_msgs), 64'd0);
    repeat (4) cycle(4'b0000, 1'b1, 1'b1);

    // Random toggles, random ready, occasional reset.
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      cur = cur ^ N'($urandom & $urandom);
      cycle(cur, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) != 0));
    end
    repeat (12) cycle(cur, 1'b1, 1'b1);
    expect_msg("drained", 1'b0, 64'd0, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/renode_input_monitor.md
Name: renode_input_monitor

Overview:
- Monitors a vector of single-bit GPIO lines driven by the HDL co-simulation and reports every level change to Renode as an "interrupt" message.
- Each message carries the line number and its new level.
- Sits between the design's interrupt/GPIO outputs and the Renode connection message channel.
- Uses a valid/ready handshake toward the message sender and serialises simultaneous changes in fixed priority order.

Parameters:
- InputsCount, 1, number of monitored lines (1..1024).
- AddressWidth, 64, width of message address field (line index).
- DataWidth, 64, width of message data field.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- inputs  input  InputsCount  monitored lines, synchronous to clk.
- msg_valid  output  1  a message is presented.
- msg_ready  input  1  consumer accepts the message; transfer when msg_valid && msg_ready at posedge.
- msg_address  output  AddressWidth  index of the changed line, zero-extended.
- msg_data  output  DataWidth  new level in bit 0; upper bits always 0.

Behaviour:
- Registers:
  - sample_q[InputsCount]: registered copy of inputs.
  - reported_q[InputsCount]: last level delivered to Renode per line.
  - Output message register.
- Reset (reset_n low at posedge): sample_q, reported_q, msg_valid, msg_address and msg_data all become 0. A transfer in flight during reset is dropped, not retried.
- After reset, lines that are 1 differ from reported_q = 0, so each is reported. This is the initial-state report.
- Every posedge out of reset: sample_q <= inputs.
- pending[i] = sample_q[i] XOR reported_q[i], combinational.
- Output slot is free when msg_valid = 0, or when msg_valid && msg_ready in this cycle.
- Slot free and some pending[i] set, excluding the line currently transferring:
  - Select the lowest index i.
  - Next cycle: msg_valid = 1, msg_address = i, msg_data = sample_q[i].
- Slot free and nothing pending: msg_valid <= 0.
- On transfer (msg_valid && msg_ready at posedge): reported_q[msg_address] <= msg_data[0].
  - A back-to-back message for another pending line may be loaded in the same cycle, giving one message per cycle at full throughput.
  - The just-transferred line is excluded from selection that cycle. It may be selected the following cycle if it toggled again.
- Stability: while msg_valid && !msg_ready, msg_address and msg_data hold stable, even if the input line changes again.
  - After the transfer, reported_q takes the sent value.
  - Any remaining mismatch produces a further message.
- Latency: input change set up before posedge E0 is captured in sample_q at E0. msg_valid rises after E1 (2 cycles) when the slot is free and no lower-index line is pending.
- Glitch policy (last-value semantics):
  - A pulse that returns to the reported level before its line is selected produces no message.
  - A pulse shorter than one clock may be missed.
- Priority: lowest index wins. No fairness is guaranteed beyond that, because pending lines drain in index order.
- msg_ready asserted while msg_valid = 0 has no effect.
- inputs X/Z are not handled. Upstream guarantees known values after reset, so the implementation does not need to handle them.
- Index wider than the line count: msg_address is always < InputsCount.

Test Plan:
- Reset with inputs = 0, hold msg_ready = 1 for 10 cycles -> msg_valid stays 0.
- InputsCount=4, inputs 0 -> 4'b0100 after reset, msg_ready = 1 -> exactly one message, address 2, data 1, valid 2 cycles after the change. Returning to 0 -> one message, address 2, data 0.
- inputs 0 -> 4'b1011 in one cycle, msg_ready = 1 -> three messages on consecutive cycles, addresses 0, 1, 3, each with data 1, then msg_valid = 0.
- Backpressure: line 1 rises while msg_ready = 0 for 5 cycles, then line 1 falls while still stalled -> message (1, 1) holds stable throughout. After msg_ready = 1: transfer (1, 1), then (1, 0).
- Reset asserted while msg_valid = 1 and msg_ready = 0 -> next cycle msg_valid = 0. Lines held at 1 through reset are re-reported after reset deasserts.
- Line 0 pulses high for one cycle while line 3's message is stalled, returning low before the slot frees -> no message for line 0.
